// File: rtl/module_spi_tx_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// module_spi_tx_seq_pkg : shared types and widths for the SPI transfer sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
package module_spi_tx_seq_pkg;

  localparam int SPI_ADDR_W = 10;
  localparam int SPI_DATA_W = 8;

  typedef logic [SPI_DATA_W-1:0] spi_byte_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    STORE = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/module_spi_tx_seq_shift_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// module_spi_shift_engine : SPI mode-0 bit engine (SCLK divider, tx/rx shifters)
// Revision: 1.0
// ----------------------------------------------------------------------------
module module_spi_shift_engine
  import module_spi_tx_seq_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_byte,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_done
);

  localparam int                 C_BIT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]         C_HALF_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [C_BIT_W-1:0] C_LAST_BIT    = C_BIT_W'(DATA_W - 1);

  logic               r_active;
  logic               r_sclk;
  logic [7:0]         r_half_cnt;
  logic [C_BIT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0]  r_tx;
  logic [DATA_W-1:0]  r_rx;
  logic               w_half_end;

  assign w_half_end = r_active && (r_half_cnt == 8'd0);
  // The last falling edge ends the byte in the same cycle the FSM leaves SHIFT
  assign byte_done  = w_half_end && r_sclk && (r_bit_cnt == C_LAST_BIT);
  assign sclk       = r_sclk;
  assign mosi       = r_active ? r_tx[DATA_W-1] : 1'b0;
  assign rx_byte    = r_rx;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_active   <= 1'b0;
      r_sclk     <= 1'b0;
      r_half_cnt <= 8'd0;
      r_bit_cnt  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
    end else if (load) begin
      r_active   <= 1'b1;
      r_sclk     <= 1'b0;
      r_half_cnt <= C_HALF_RELOAD;
      r_bit_cnt  <= '0;
      r_tx       <= tx_byte;
    end else if (r_active) begin
      if (!w_half_end) begin
        r_half_cnt <= r_half_cnt - 8'd1;
      end else begin
        r_half_cnt <= C_HALF_RELOAD;
        r_sclk     <= ~r_sclk;
        if (!r_sclk) begin
          r_rx <= {r_rx[DATA_W-2:0], miso};
        end else begin
          r_tx      <= r_tx << 1;
          r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
          if (r_bit_cnt == C_LAST_BIT) begin
            r_active <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/module_spi_tx_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// module_spi_tx_seq : streams buffer bytes 0..n_tx out over SPI, writes MISO bytes back
// Revision: 1.0
// ----------------------------------------------------------------------------
module module_spi_tx_seq
  import module_spi_tx_seq_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = SPI_ADDR_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] n_tx_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              hold_ctrl_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  spi_state_t        r_state;
  spi_state_t        w_state_next;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_n_tx;
  logic              w_load;
  logic              w_byte_done;
  logic [DATA_W-1:0] w_rx_byte;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_index <= '0;
      r_n_tx  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && start_i) begin
        r_n_tx  <= n_tx_i;
        r_index <= '0;
      end else if (r_state == NEXT && r_index != r_n_tx) begin
        r_index <= r_index + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    hold_ctrl_o  = 1'b1;
    wr_o         = 1'b0;
    w_load       = 1'b0;
    cs_n_o       = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o      = 1'b0;
        hold_ctrl_o = 1'b0;
        cs_n_o      = 1'b1;
        if (start_i) w_state_next = FETCH;
      end
      FETCH: begin
        // Chip select only drops for the first byte once it has been fetched
        cs_n_o       = (r_index == '0);
        w_state_next = LOAD;
      end
      LOAD: begin
        w_load       = 1'b1;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_byte_done) w_state_next = STORE;
      end
      STORE: begin
        wr_o         = 1'b1;
        w_state_next = NEXT;
      end
      NEXT: begin
        w_state_next = (r_index == r_n_tx) ? DONE : FETCH;
      end
      DONE: begin
        hold_ctrl_o  = 1'b0;
        cs_n_o       = 1'b1;
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        busy_o       = 1'b0;
        hold_ctrl_o  = 1'b0;
        cs_n_o       = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  assign addr_o    = hold_ctrl_o ? r_index : '0;
  assign wr_data_o = w_rx_byte;

  module_spi_shift_engine #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_engine (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (w_load),
    .tx_byte   (rd_data_i),
    .miso      (miso_i),
    .sclk      (sclk_o),
    .mosi      (mosi_o),
    .rx_byte   (w_rx_byte),
    .byte_done (w_byte_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_module_spi_tx_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_module_spi_tx_seq : directed vector bench for module_spi_tx_seq (CLK_DIV 2 and 1)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_module_spi_tx_seq;
  import module_spi_tx_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: CLK_DIV = 2
  logic       start_a = 1'b0;
  logic [9:0] n_tx_a  = '0;
  logic       busy_a, done_a, hold_a, wr_a, cs_n_a, sclk_a, mosi_a, miso_a;
  logic [9:0] addr_a;
  spi_byte_t  rd_a, wr_data_a;
  logic [1:0] miso_mode = 2'd0;  // 0: const 0, 1: const 1, 2: loopback
  assign miso_a = (miso_mode == 2'd2) ? mosi_a : miso_mode[0];

  // DUT B: CLK_DIV = 1, with a mode-0 slave answering 0xC3
  logic       start_b = 1'b0;
  logic [9:0] n_tx_b  = '0;
  logic       busy_b, done_b, hold_b, wr_b, cs_n_b, sclk_b, mosi_b, miso_b;
  logic [9:0] addr_b;
  spi_byte_t  rd_b, wr_data_b;
  logic [7:0] slave_byte = 8'hC3;
  logic [2:0] s_cnt = 3'd0;
  always @(negedge sclk_b) if (!cs_n_b) s_cnt <= s_cnt + 3'd1;
  assign miso_b = slave_byte[3'd7 - s_cnt];

  module_spi_tx_seq #(.CLK_DIV(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .n_tx_i(n_tx_a),
    .busy_o(busy_a), .done_o(done_a), .hold_ctrl_o(hold_a), .addr_o(addr_a),
    .rd_data_i(rd_a), .wr_o(wr_a), .wr_data_o(wr_data_a), .cs_n_o(cs_n_a),
    .sclk_o(sclk_a), .mosi_o(mosi_a), .miso_i(miso_a)
  );

  module_spi_tx_seq #(.CLK_DIV(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .n_tx_i(n_tx_b),
    .busy_o(busy_b), .done_o(done_b), .hold_ctrl_o(hold_b), .addr_o(addr_b),
    .rd_data_i(rd_b), .wr_o(wr_b), .wr_data_o(wr_data_b), .cs_n_o(cs_n_b),
    .sclk_o(sclk_b), .mosi_o(mosi_b), .miso_i(miso_b)
  );

  // Buffer models with a host preload port
  spi_byte_t  mem_a [1024];
  spi_byte_t  mem_b [1024];
  logic       host_we_a = 1'b0, host_we_b = 1'b0;
  logic [9:0] host_addr = '0;
  spi_byte_t  host_data = '0;
  always @(posedge clk) begin
    if (host_we_a) mem_a[host_addr] <= host_data;
    else if (wr_a) mem_a[addr_a] <= wr_data_a;
    if (host_we_b) mem_b[host_addr] <= host_data;
    else if (wr_b) mem_b[addr_b] <= wr_data_b;
    rd_a <= mem_a[addr_a];
    rd_b <= mem_b[addr_b];
  end

  // Monitor A
  int   wr_addr_q[$];
  int   wr_data_q[$];
  logic mosi_q[$];
  int   rise_a = 0, done_cnt_a = 0, cs_fall_a = 0, cs_low_a = 0, own_err_a = 0, per_err_a = 0;
  int   rib_a = 0, last_rise_a = 0;
  logic prev_sclk_a = 1'b0, prev_cs_a = 1'b1;
  always @(negedge clk) begin
    prev_sclk_a <= sclk_a;
    prev_cs_a   <= cs_n_a;
    if (wr_a) begin
      wr_addr_q.push_back(int'(addr_a));
      wr_data_q.push_back(int'(wr_data_a));
    end
    if (sclk_a && !prev_sclk_a) begin
      rise_a <= rise_a + 1;
      mosi_q.push_back(mosi_a);
      if (rib_a != 0 && cyc - last_rise_a != 4) per_err_a <= per_err_a + 1;
      rib_a       <= (rib_a == 7) ? 0 : rib_a + 1;
      last_rise_a <= cyc;
    end else if (!busy_a) begin
      rib_a <= 0;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (!cs_n_a && prev_cs_a) cs_fall_a <= cs_fall_a + 1;
    if (!cs_n_a) cs_low_a <= cs_low_a + 1;
    if ((!hold_a && wr_a) || (!busy_a && hold_a) || (done_a && hold_a) ||
        (busy_a && !done_a && !hold_a))
      own_err_a <= own_err_a + 1;
  end

  // Monitor B
  int         rise_b = 0, per_err_b = 0, last_rise_b = 0, wr_cnt_b = 0;
  logic [7:0] mosi_byte_b = '0;
  int         wb_addr = -1, wb_data = -1;
  logic       prev_sclk_b = 1'b0;
  always @(negedge clk) begin
    prev_sclk_b <= sclk_b;
    if (sclk_b && !prev_sclk_b) begin
      rise_b      <= rise_b + 1;
      mosi_byte_b <= {mosi_byte_b[6:0], mosi_b};
      if (rise_b != 0 && cyc - last_rise_b != 2) per_err_b <= per_err_b + 1;
      last_rise_b <= cyc;
    end
    if (wr_b) begin
      wb_addr  <= int'(addr_b);
      wb_data  <= int'(wr_data_b);
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic host_write_a(input logic [9:0] a, input spi_byte_t d);
    @(negedge clk); host_we_a = 1'b1; host_addr = a; host_data = d;
    @(negedge clk); host_we_a = 1'b0;
  endtask

  task automatic start_pulse_a(input logic [9:0] n);
    @(negedge clk); start_a = 1'b1; n_tx_a = n;
    @(negedge clk); start_a = 1'b0; n_tx_a = 10'd7;
  endtask

  // lat counts rising edges from the start sample edge (1) to the edge showing done
  task automatic wait_done_a(inout int lat);
    while (done_a !== 1'b1 && lat < 40000) begin
      @(negedge clk); lat++;
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct packed {
    logic [9:0]  n_tx;
    logic [1:0]  mode;
    logic [31:0] tx;
    logic [31:0] exp;
    logic [15:0] lat;
  } vec_t;
  vec_t vecs [4];

  task automatic run_vec(input vec_t v, input string tag);
    int nb, lat, w0, r0, d0, cf0, cl0, oe0, pe0, m0;
    logic [7:0] got;
    nb = int'(v.n_tx) + 1;
    for (int i = 0; i < nb; i++) host_write_a(10'(i), v.tx[31-8*i -: 8]);
    miso_mode = v.mode;
    w0 = wr_addr_q.size(); r0 = rise_a; d0 = done_cnt_a; cf0 = cs_fall_a;
    cl0 = cs_low_a; oe0 = own_err_a; pe0 = per_err_a; m0 = mosi_q.size();
    start_pulse_a(v.n_tx);
    lat = 1;
    wait_done_a(lat);
    check({tag, "_latency"}, lat, int'(v.lat));
    check({tag, "_done_pulses"}, done_cnt_a - d0, 1);
    check({tag, "_writes"}, wr_addr_q.size() - w0, nb);
    if (wr_addr_q.size() - w0 == nb) begin
      for (int i = 0; i < nb; i++) begin
        check({tag, "_wr_addr"}, wr_addr_q[w0+i], i);
        check({tag, "_wr_data"}, wr_data_q[w0+i], int'(v.exp[31-8*i -: 8]));
        check({tag, "_mem"}, int'(mem_a[i]), int'(v.exp[31-8*i -: 8]));
      end
    end
    check({tag, "_sclk_rises"}, rise_a - r0, 8 * nb);
    if (mosi_q.size() >= m0 + 8 * nb) begin
      for (int i = 0; i < nb; i++) begin
        got = '0;
        for (int b = 0; b < 8; b++) got = {got[6:0], mosi_q[m0+8*i+b]};
        check({tag, "_mosi_byte"}, int'(got), int'(v.tx[31-8*i -: 8]));
      end
    end
    check({tag, "_cs_falls"}, cs_fall_a - cf0, 1);
    check({tag, "_cs_low_cycles"}, cs_low_a - cl0, nb * (16 * 2 + 4) - 1);
    check({tag, "_ownership_errs"}, own_err_a - oe0, 0);
    check({tag, "_sclk_period_errs"}, per_err_a - pe0, 0);
  endtask

  initial begin
    int lat, w0, d0, oe0, order_err;

    vecs[0] = '{n_tx: 10'd0, mode: 2'd2, tx: 32'hA500_0000, exp: 32'hA500_0000, lat: 16'd37};
    vecs[1] = '{n_tx: 10'd2, mode: 2'd1, tx: 32'h0180_3C00, exp: 32'hFFFF_FF00, lat: 16'd109};
    vecs[2] = '{n_tx: 10'd1, mode: 2'd0, tx: 32'hC35A_0000, exp: 32'h0000_0000, lat: 16'd73};
    vecs[3] = '{n_tx: 10'd3, mode: 2'd2, tx: 32'h1234_5678, exp: 32'h1234_5678, lat: 16'd145};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_bits", int'({cs_n_a, sclk_a, mosi_a, busy_a, done_a, hold_a, wr_a}), 'b1000000);
    check("reset_addr", int'(addr_a), 0);
    check("reset_wr_data", int'(wr_data_a), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Start while busy is ignored
    host_write_a(10'd0, 8'h3C);
    miso_mode = 2'd2;
    w0 = wr_addr_q.size(); d0 = done_cnt_a;
    start_pulse_a(10'd0);
    repeat (18) @(negedge clk);
    start_a = 1'b1; n_tx_a = 10'd5;
    @(negedge clk); start_a = 1'b0;
    lat = 20;
    wait_done_a(lat);
    repeat (60) @(negedge clk);
    check("busy_start_done_pulses", done_cnt_a - d0, 1);
    check("busy_start_writes", wr_addr_q.size() - w0, 1);
    if (wr_addr_q.size() - w0 == 1) begin
      check("busy_start_wr_addr", wr_addr_q[w0], 0);
      check("busy_start_wr_data", wr_data_q[w0], 'h3C);
    end
    check("busy_start_idle", int'(busy_a), 0);

    // Reset during SHIFT cycle 10 of the first byte
    host_write_a(10'd0, 8'hF0);
    w0 = wr_addr_q.size(); d0 = done_cnt_a;
    start_pulse_a(10'd0);
    repeat (11) @(negedge clk);
    check("midreset_was_busy", int'(busy_a), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_ctrl_bits", int'({cs_n_a, sclk_a, mosi_a, busy_a, done_a, hold_a, wr_a}), 'b1000000);
    check("midreset_wr_data", int'(wr_data_a), 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset_no_write", wr_addr_q.size() - w0, 0);
    check("midreset_no_done", done_cnt_a - d0, 0);
    run_vec(vecs[0], "after_reset");

    // Full-buffer transfer, index must stop at 1023
    miso_mode = 2'd1;
    w0 = wr_addr_q.size(); d0 = done_cnt_a; oe0 = own_err_a;
    start_pulse_a(10'd1023);
    lat = 1;
    wait_done_a(lat);
    check("full_latency", lat, 1024 * 36 + 1);
    check("full_writes", wr_addr_q.size() - w0, 1024);
    order_err = 0;
    for (int i = 0; i < 1024 && w0 + i < wr_addr_q.size(); i++)
      if (wr_addr_q[w0+i] != i || wr_data_q[w0+i] != 'hFF) order_err++;
    check("full_order_errs", order_err, 0);
    check("full_done_pulses", done_cnt_a - d0, 1);
    check("full_ownership_errs", own_err_a - oe0, 0);

    // CLK_DIV = 1 against the external slave
    @(negedge clk); host_we_b = 1'b1; host_addr = 10'd0; host_data = 8'h5A;
    @(negedge clk); host_we_b = 1'b0;
    @(negedge clk); start_b = 1'b1; n_tx_b = 10'd0;
    @(negedge clk); start_b = 1'b0;
    lat = 1;
    while (done_b !== 1'b1 && lat < 1000) begin
      @(negedge clk); lat++;
    end
    repeat (3) @(negedge clk);
    check("div1_latency", lat, 21);
    check("div1_sclk_rises", rise_b, 8);
    check("div1_period_errs", per_err_b, 0);
    check("div1_mosi_byte", int'(mosi_byte_b), 'h5A);
    check("div1_writes", wr_cnt_b, 1);
    check("div1_wr_addr", wb_addr, 0);
    check("div1_wr_data", wb_data, 'hC3);
    check("div1_mem", int'(mem_b[0]), 'hC3);
    check("div1_idle", int'({busy_b, hold_b}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
